shift_sequencer: RTL and testbench

- Multi-cycle shift unit for the LC-3b SHF instruction: performs LSHF / RSHFL / RSHFA one bit position per clock instead of with a combinational barrel shifter.
- Sits beside the ALU in the execute stage; the control FSM pulses START with the IR[5:0] shift field and the SR1 operand, then waits for DONE.
- Holds the result stable until the next accepted request, so it can drive the DR write-back mux directly.

---
 rtl/shift_sequencer_if.sv | 24 ++
 rtl/shift_sequencer.sv | 114 +++++++++++
 tb/tb_shift_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the execute-stage control FSM and the shift sequencer.
// The requester drives START/IR6/SR1; the sequencer returns BUSY/DONE/ERR/OUT.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
);
    logic             START;
    logic [AMT_W+1:0] IR6;
    logic [WIDTH-1:0] SR1;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic [WIDTH-1:0] OUT;

    modport master (
        output START, IR6, SR1,
        input  BUSY, DONE, ERR, OUT
    );

    modport slave (
        input  START, IR6, SR1,
        output BUSY, DONE, ERR, OUT
    );
endinterface

// File: rtl/shift_sequencer.sv
// Bit-serial LC-3b SHF unit: LSHF / RSHFL / RSHFA, one bit position per clock.
// The result and error flag are held in registers until the next completion.
module shift_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic               CLK,
    input  logic               RESET_N,
    shift_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StFin   = 2'd2
    } state_e;

    localparam logic [1:0] TypeLeft    = 2'b00;
    localparam logic [1:0] TypeRightL  = 2'b01;
    localparam logic [1:0] TypeInvalid = 2'b10;
    localparam logic [1:0] TypeRightA  = 2'b11;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic [1:0]         type_q, type_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   shifted;
    logic [1:0]         req_type;
    logic [AMT_W-1:0]   req_amt;

    assign req_type = bus.IR6[AMT_W+1:AMT_W];
    assign req_amt  = bus.IR6[AMT_W-1:0];

    always_comb begin
        shifted = work_q;
        unique case (type_q)
            TypeLeft:   shifted = {work_q[WIDTH-2:0], 1'b0};
            TypeRightL: shifted = {1'b0, work_q[WIDTH-1:1]};
            TypeRightA: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default:    shifted = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        type_d  = type_q;
        out_d   = out_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.START) begin
                    work_d  = bus.SR1;
                    type_d  = req_type;
                    count_d = req_amt;
                    if (req_type == TypeInvalid) begin
                        state_d = StFin;
                        out_d   = '0;
                        err_d   = 1'b1;
                    end else if (req_amt == '0) begin
                        state_d = StFin;
                        out_d   = bus.SR1;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d  = shifted;
                count_d = count_q - 1'b1;
                // Result is captured on the same edge that enters FIN.
                if (count_q == AMT_W'(1)) begin
                    state_d = StFin;
                    out_d   = shifted;
                    err_d   = 1'b0;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            work_q  <= '0;
            count_q <= '0;
            type_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            type_q  <= type_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign bus.BUSY = (state_q != StIdle);
    assign bus.DONE = (state_q == StFin);
    assign bus.ERR  = err_q;
    assign bus.OUT  = out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random requests
// compared against an arithmetic reference model of the SHF rules.
module tb_shift_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] prev_out;
    logic        prev_err;

    shift_sequencer_if #(.WIDTH(16), .AMT_W(4)) bus ();

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, error flag and number of cycles from accept to DONE.
    task automatic model(input logic [5:0] ir, input logic [15:0] a,
                         output logic [15:0] res, output logic err, output int lat);
        logic signed [15:0] s;
        int amt;
        amt = int'(ir[3:0]);
        s   = a;
        err = 1'b0;
        lat = amt + 1;
        case (ir[5:4])
            2'b00:   res = a << amt;
            2'b01:   res = a >> amt;
            2'b11:   res = s >>> amt;
            default: begin res = 16'h0000; err = 1'b1; lat = 1; end
        endcase
    endtask

    // Presents a request at a negedge while idle; returns just after the accept edge.
    task automatic issue(input logic [5:0] ir, input logic [15:0] a);
        @(negedge clk);
        chk("idle_before_req", {31'b0, bus.BUSY}, 32'd0);
        bus.IR6   = ir;
        bus.SR1   = a;
        bus.START = 1'b1;
        @(negedge clk);
    endtask

    // Called at the first negedge after the accept edge; follows the op to IDLE.
    task automatic finish(input logic [5:0] ir, input logic [15:0] a);
        logic [15:0] exp_out;
        logic        exp_err;
        int          lat;
        int          cyc;
        model(ir, a, exp_out, exp_err, lat);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.DONE === 1'b1) begin
                cyc = i;
                break;
            end
            chk("busy_in_shift", {31'b0, bus.BUSY}, 32'd1);
            chk("out_hold", {16'b0, bus.OUT}, {16'b0, prev_out});
            chk("err_hold", {31'b0, bus.ERR}, {31'b0, prev_err});
            @(negedge clk);
        end
        chk("done_latency", cyc, lat);
        chk("busy_in_fin", {31'b0, bus.BUSY}, 32'd1);
        chk("result", {16'b0, bus.OUT}, {16'b0, exp_out});
        chk("err_flag", {31'b0, bus.ERR}, {31'b0, exp_err});
        prev_out = exp_out;
        prev_err = exp_err;
        @(negedge clk);
        chk("idle_after_fin", {30'b0, bus.BUSY, bus.DONE}, 32'd0);
        chk("out_idle_hold", {16'b0, bus.OUT}, {16'b0, prev_out});
    endtask

    task automatic single(input logic [5:0] ir, input logic [15:0] a);
        issue(ir, a);
        bus.START = 1'b0;
        bus.IR6   = 6'($urandom);
        bus.SR1   = 16'($urandom);
        finish(ir, a);
    endtask

    initial begin
        logic [5:0]  rir;
        logic [15:0] ra;
        checks    = 0;
        errors    = 0;
        prev_out  = 16'h0000;
        prev_err  = 1'b0;
        bus.START = 1'b0;
        bus.IR6   = '0;
        bus.SR1   = '0;
        rst_n     = 1'b0;
        #12;
        chk("reset_state", {13'b0, bus.BUSY, bus.DONE, bus.ERR, bus.OUT}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort mid-shift with an asynchronous reset.
        issue(6'b00_1001, 16'hA5A5);
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_abort", {31'b0, bus.BUSY}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, bus.BUSY}, 32'd0);
        chk("abort_out", {16'b0, bus.OUT}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", {30'b0, bus.BUSY, bus.DONE}, 32'd0);
        end

        single(6'b00_0011, 16'h1234);
        chk("lshf3", {16'b0, bus.OUT}, 32'h91A0);
        single(6'b11_0100, 16'h8F00);
        chk("rshfa4", {16'b0, bus.OUT}, 32'hF8F0);
        single(6'b01_0100, 16'h8F00);
        chk("rshfl4", {16'b0, bus.OUT}, 32'h08F0);
        single(6'b11_1111, 16'h8000);
        chk("rshfa15", {16'b0, bus.OUT}, 32'hFFFF);
        single(6'b00_0000, 16'hBEEF);
        chk("amt0", {16'b0, bus.OUT}, 32'hBEEF);
        single(6'b10_0101, 16'h1357);
        chk("invalid_err", {15'b0, bus.ERR, bus.OUT}, 32'h1_0000);
        single(6'b01_1111, 16'h8001);
        chk("err_cleared", {15'b0, bus.ERR, bus.OUT}, 32'h0000_0001);
        single(6'b00_1111, 16'h0003);
        chk("lshf15", {16'b0, bus.OUT}, 32'h8000);

        // START held high: second op uses inputs present when IDLE is reached.
        issue(6'b00_0101, 16'h00F1);
        bus.IR6 = 6'b11_0010;
        bus.SR1 = 16'h8004;
        finish(6'b00_0101, 16'h00F1);
        chk("held_first", {16'b0, prev_out}, 32'h1E20);
        @(negedge clk);
        bus.START = 1'b0;
        finish(6'b11_0010, 16'h8004);
        chk("held_second", {16'b0, bus.OUT}, 32'hE001);

        for (int n = 0; n < 40; n++) begin
            rir = 6'($urandom);
            ra  = 16'($urandom);
            single(rir, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
